// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared definitions for the median-filter video path:
//   - default geometry constants for the line/frame controller
//   - event classification enum used by the controller's decode stage
//   - sel_inc(): line-buffer index increment modulo the number of buffers
// -----------------------------------------------------------------------------
package median_pkg;

  localparam int DEF_ADDR_W    = 11;
  localparam int DEF_ROW_W     = 11;
  localparam int DEF_NUM_LINES = 3;

  // What the controller does this cycle. Frame sync outranks line sync,
  // and pixels arriving on a sync cycle are treated as blanking.
  typedef enum logic [1:0] {
    EV_IDLE,
    EV_PIXEL,
    EV_LINE,
    EV_FRAME
  } ctrl_ev_e;

  // Next line-buffer index in the rotation 0 .. num-1.
  function automatic int unsigned sel_inc(input int unsigned sel,
                                          input int unsigned num);
    return (sel + 32'd1 >= num) ? 32'd0 : sel + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Rising-edge detector for a signal already synchronous to clk.
// The registered copy resets to RST_VAL, so with RST_VAL=1 a level that is
// already high when reset releases does not produce a pulse.
//
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-low reset
//   i_sig   in  level to watch
//   o_rise  out combinational pulse: i_sig high and previous sample low
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_q;

endmodule

// File: rtl/line_frame_ctrl.sv
// -----------------------------------------------------------------------------
// line_frame_ctrl
// Pixel address counter and line/frame bookkeeping for the line-buffer bank
// feeding the NxN median window. Counts pixels within a line, records the
// width of the last non-empty line and the height of the last frame, and
// rotates the write target over NUM_LINES line buffers.
//
// Ports:
//   clk         in  clock, rising edge
//   rst         in  synchronous active-low reset
//   vsync       in  frame sync (active high, rising edge used)
//   hsync       in  line sync (active high, rising edge used)
//   pix_en      in  pixel valid this cycle
//   addr        out write address for the pixel presented this cycle
//   width       out pixel count of the last completed non-empty line
//   row         out index of the line currently being written
//   height      out non-empty line count of the last completed frame
//   wr_sel      out line buffer currently written
//   old_sel     out line buffer holding the oldest stored line
//   window_rdy  out enough rows stored for a full window
//   line_done   out one-cycle pulse per completed non-empty line
//   frame_done  out one-cycle pulse per vsync edge
//   ovf         out sticky within a frame: address or row counter saturated
// -----------------------------------------------------------------------------
module line_frame_ctrl
  import median_pkg::*;
#(
  parameter  int ADDR_W    = DEF_ADDR_W,
  parameter  int ROW_W     = DEF_ROW_W,
  parameter  int NUM_LINES = DEF_NUM_LINES,
  localparam int SEL_W     = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              hsync,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] width,
  output logic [ROW_W-1:0]  row,
  output logic [ROW_W-1:0]  height,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [SEL_W-1:0]  old_sel,
  output logic              window_rdy,
  output logic              line_done,
  output logic              frame_done,
  output logic              ovf
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_width;
  logic [ROW_W-1:0]  r_row;
  logic [ROW_W-1:0]  r_height;
  logic [SEL_W-1:0]  r_wr_sel;
  logic              r_line_done;
  logic              r_frame_done;
  logic              r_ovf;

  logic              w_hs_rise;
  logic              w_vs_rise;
  ctrl_ev_e          w_ev;
  logic              w_line_open;
  logic              w_addr_max;
  logic              w_row_max;
  logic [ROW_W-1:0]  w_row_inc;
  logic [SEL_W-1:0]  w_sel_next;

  // Sync registers reset high: a sync level already asserted at reset
  // release is not mistaken for a fresh edge.
  sync_edge_det #(.RST_VAL(1'b1)) u_hs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (hsync),
    .o_rise (w_hs_rise)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (vsync),
    .o_rise (w_vs_rise)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_ev = EV_IDLE;
    if (w_vs_rise) begin
      w_ev = EV_FRAME;
    end else if (w_hs_rise) begin
      w_ev = EV_LINE;
    end else if (pix_en) begin
      w_ev = EV_PIXEL;
    end
  end

  assign w_line_open = (r_addr != '0);
  assign w_addr_max  = &r_addr;
  assign w_row_max   = &r_row;
  assign w_row_inc   = w_row_max ? r_row : r_row + ROW_W'(1);
  assign w_sel_next  = SEL_W'(sel_inc(32'(r_wr_sel), 32'(NUM_LINES)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr       <= '0;
      r_width      <= '0;
      r_row        <= '0;
      r_height     <= '0;
      r_wr_sel     <= '0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;

      case (w_ev)
        EV_PIXEL: begin
          if (w_addr_max) begin
            r_ovf <= 1'b1;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end

        // Blank lines (no pixels since the last sync) are invisible: no
        // row advance, no rotation, no pulse.
        EV_LINE: begin
          if (w_line_open) begin
            r_width     <= r_addr;
            r_addr      <= '0;
            r_row       <= w_row_inc;
            r_wr_sel    <= w_sel_next;
            r_line_done <= 1'b1;
            if (w_row_max) begin
              r_ovf <= 1'b1;
            end
          end
        end

        // Frame sync closes any open line first, so the height includes it;
        // the whole frame context then restarts from buffer 0.
        EV_FRAME: begin
          if (w_line_open) begin
            r_width     <= r_addr;
            r_height    <= w_row_inc;
            r_line_done <= 1'b1;
          end else begin
            r_height    <= r_row;
          end
          r_addr       <= '0;
          r_row        <= '0;
          r_wr_sel     <= '0;
          r_ovf        <= 1'b0;
          r_frame_done <= 1'b1;
        end

        default: begin
        end
      endcase
    end
  end

  assign addr       = r_addr;
  assign width      = r_width;
  assign row        = r_row;
  assign height     = r_height;
  assign wr_sel     = r_wr_sel;
  assign line_done  = r_line_done;
  assign frame_done = r_frame_done;
  assign ovf        = r_ovf;
  assign old_sel    = w_sel_next;
  assign window_rdy = (r_row >= ROW_W'(NUM_LINES - 1));

endmodule

// File: tb/tb_line_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_frame_ctrl
// Scoreboard bench for line_frame_ctrl. The stimulus process keeps a
// pixel/line/frame model in plain integers and queues the expected content
// of every line_done / frame_done pulse; a negedge monitor pops and compares
// whenever the DUT pulses. A second instance with ADDR_W=4 covers address
// saturation.
// -----------------------------------------------------------------------------
module tb_line_frame_ctrl;

  localparam int NL       = 3;
  localparam int ADDR_MAX = 2047;
  localparam int ROW_MAX  = 2047;

  typedef struct {
    int due;
    int width;
    int row;
    int sel;
  } line_exp_t;

  typedef struct {
    int due;
    int height;
  } frame_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0, pix_en = 1'b0;
  logic [10:0] addr, width, row, height;
  logic [1:0]  wr_sel, old_sel;
  logic        window_rdy, line_done, frame_done, ovf;

  logic        hsync4 = 1'b0, vsync4 = 1'b0, pix4 = 1'b0;
  logic [3:0]  addr4, width4;
  logic [10:0] row4, height4;
  logic [1:0]  wr_sel4, old_sel4;
  logic        window_rdy4, line_done4, frame_done4, ovf4;

  line_frame_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync),
    .hsync      (hsync),
    .pix_en     (pix_en),
    .addr       (addr),
    .width      (width),
    .row        (row),
    .height     (height),
    .wr_sel     (wr_sel),
    .old_sel    (old_sel),
    .window_rdy (window_rdy),
    .line_done  (line_done),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  line_frame_ctrl #(.ADDR_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .vsync      (vsync4),
    .hsync      (hsync4),
    .pix_en     (pix4),
    .addr       (addr4),
    .width      (width4),
    .row        (row4),
    .height     (height4),
    .wr_sel     (wr_sel4),
    .old_sel    (old_sel4),
    .window_rdy (window_rdy4),
    .line_done  (line_done4),
    .frame_done (frame_done4),
    .ovf        (ovf4)
  );

  always #5 clk = ~clk;

  int n_cyc = 0;
  always @(posedge clk) n_cyc <= n_cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, want, n_cyc);
  endtask

  // Behavioural model: pixels in the open line, non-empty lines closed this
  // frame, buffer in rotation, overflow flag, last sampled sync levels.
  int         m_pix = 0, m_lines = 0, m_sel = 0;
  bit         m_ovf = 1'b0, m_hs = 1'b1, m_vs = 1'b1;
  line_exp_t  line_q[$];
  frame_exp_t frame_q[$];

  task automatic check_state(input string name);
    check(name,
          {addr, row, wr_sel, old_sel, window_rdy, ovf},
          {11'(m_pix), 11'(m_lines), 2'(m_sel), 2'((m_sel + 1) % NL),
           1'(m_lines >= NL - 1), m_ovf});
  endtask

  // One clock with the given inputs; the model is advanced first so the
  // expected pulse is queued before the DUT can produce it.
  task automatic cyc(input bit h, input bit v, input bit p);
    line_exp_t  le;
    frame_exp_t fe;
    bit he, ve;
    he = h && !m_hs;
    ve = v && !m_vs;
    m_hs = h;
    m_vs = v;
    if (ve) begin
      int closed;
      closed = m_lines;
      if (m_pix > 0) begin
        closed = (m_lines == ROW_MAX) ? ROW_MAX : m_lines + 1;
        le.due = n_cyc + 1; le.width = m_pix; le.row = 0; le.sel = 0;
        line_q.push_back(le);
      end
      fe.due = n_cyc + 1; fe.height = closed;
      frame_q.push_back(fe);
      m_pix = 0; m_lines = 0; m_sel = 0; m_ovf = 1'b0;
    end else if (he) begin
      if (m_pix > 0) begin
        if (m_lines == ROW_MAX) m_ovf = 1'b1;
        else m_lines++;
        m_sel = (m_sel + 1) % NL;
        le.due = n_cyc + 1; le.width = m_pix; le.row = m_lines; le.sel = m_sel;
        line_q.push_back(le);
        m_pix = 0;
      end
    end else if (p) begin
      if (m_pix == ADDR_MAX) m_ovf = 1'b1;
      else m_pix++;
    end
    hsync  = h;
    vsync  = v;
    pix_en = p;
    @(posedge clk);
    #1;
    check_state("state");
  endtask

  // One clock with reset asserted; sync history restarts as "high".
  task automatic rcyc(input bit h, input bit v, input bit p);
    rst    = 1'b0;
    hsync  = h;
    vsync  = v;
    pix_en = p;
    m_pix = 0; m_lines = 0; m_sel = 0; m_ovf = 1'b0; m_hs = 1'b1; m_vs = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_state("reset_state");
    check("reset_width_height", {width, height}, 22'd0);
  endtask

  task automatic cyc4(input bit h, input bit v, input bit p);
    hsync4 = h;
    vsync4 = v;
    pix4   = p;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every pulse must match the head of its queue, on time.
  always @(negedge clk) begin
    line_exp_t  le;
    frame_exp_t fe;
    if (line_done === 1'b1) begin
      if (line_q.size() == 0) begin
        check("line_done_unexpected", 64'(line_done), 64'd0);
      end else begin
        le = line_q.pop_front();
        check("line_due", n_cyc, le.due);
        check("line_width", width, le.width);
        check("line_row", row, le.row);
        check("line_wr_sel", wr_sel, le.sel);
        check("line_old_sel", old_sel, (le.sel + 1) % NL);
        check("line_window_rdy", window_rdy, le.row >= NL - 1);
      end
    end else if (line_q.size() > 0 && line_q[0].due <= n_cyc) begin
      check("line_done_missing", 64'(line_done), 64'd1);
      void'(line_q.pop_front());
    end

    if (frame_done === 1'b1) begin
      if (frame_q.size() == 0) begin
        check("frame_done_unexpected", 64'(frame_done), 64'd0);
      end else begin
        fe = frame_q.pop_front();
        check("frame_due", n_cyc, fe.due);
        check("frame_height", height, fe.height);
      end
    end else if (frame_q.size() > 0 && frame_q[0].due <= n_cyc) begin
      check("frame_done_missing", 64'(frame_done), 64'd1);
      void'(frame_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with hsync held high, then hold it: no edge, all outputs zero.
    rcyc(1'b1, 1'b0, 1'b0);
    rcyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    check("t1_width", width, 11'd0);
    check("t1_height", height, 11'd0);
    check("t1_line_done", line_done, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Two blank lines: no row advance, no rotation, no pulse.
    repeat (2) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    check("t3_row", row, 11'd0);
    check("t3_wr_sel", wr_sel, 2'd0);

    // Four 10-pixel lines; the last one is closed by vsync.
    for (int l = 0; l < 4; l++) begin
      repeat (10) cyc(1'b0, 1'b0, 1'b1);
      if (l < 3) cyc(1'b1, 1'b0, 1'b0);
      else       cyc(1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    check("t2_width", width, 11'd10);
    check("t2_height", height, 11'd4);

    // hsync and vsync together after 7 pixels: line closed once.
    repeat (7) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    check("t4_width", width, 11'd7);
    check("t4_height", height, 11'd1);
    check("t4_row_sel", {row, wr_sel}, 13'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset 5 pixels into row 1, then a normal frame.
    repeat (6) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    check("t6_addr_before", addr, 11'd5);
    rcyc(1'b0, 1'b0, 1'b1);
    repeat (3) begin
      repeat (8) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t6_height", height, 11'd3);
    check("t6_width", width, 11'd8);

    // Narrow address counter: 20 pixels saturate at 15.
    repeat (20) cyc4(1'b0, 1'b0, 1'b1);
    check("ovf4_addr", addr4, 4'd15);
    check("ovf4_flag", ovf4, 1'b1);
    cyc4(1'b1, 1'b0, 1'b0);
    check("ovf4_width", width4, 4'd15);
    check("ovf4_line_done", line_done4, 1'b1);
    check("ovf4_flag_kept", ovf4, 1'b1);
    cyc4(1'b0, 1'b1, 1'b0);
    check("ovf4_frame_done", frame_done4, 1'b1);
    check("ovf4_cleared", ovf4, 1'b0);
    check("ovf4_height", height4, 11'd1);
    cyc4(1'b0, 1'b0, 1'b0);

    // Randomised frames: gaps, blank lines, long syncs, pixels on sync
    // cycles, open lines closed by vsync, simultaneous syncs.
    for (int f = 0; f < 40; f++) begin
      int nl;
      nl = $urandom_range(0, 5);
      for (int l = 0; l < nl; l++) begin
        int np, k;
        np = $urandom_range(0, 14);
        k  = 0;
        while (k < np) begin
          if ($urandom_range(0, 3) != 0) begin
            cyc(1'b0, 1'b0, 1'b1);
            k++;
          end else begin
            cyc(1'b0, 1'b0, 1'b0);
          end
        end
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) cyc(1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 2) == 0) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      else                           cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("line_q_drained", line_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
